// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM state, control-bundle type and defaults for pipeline_hazard_ctrl
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_IDLE     = 7'b1111_000;
    localparam hz_ctrl_t CTRL_MEM_WAIT = 7'b0000_001;
    localparam hz_ctrl_t CTRL_BRANCH   = 7'b1111_110;
    localparam hz_ctrl_t CTRL_STALL    = 7'b0011_010;
    localparam hz_ctrl_t CTRL_FLUSH    = 7'b1111_100;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-side signals of the hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_jump;
    logic              ex_mem_read;
    logic              ex_reg_write;
    logic [REG_AW-1:0] ex_wreg;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_wreg;
    logic              ex_branch_taken;
    logic              dmem_req;
    logic              dmem_ready;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_write;
    logic              ex_mem_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              mem_wb_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              busy;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_jump,
        output ex_mem_read, ex_reg_write, ex_wreg, mem_reg_write, mem_wreg,
        output ex_branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_bubble, mem_wb_bubble,
        input  stall_cnt, flush_cnt, busy
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_jump,
        input  ex_mem_read, ex_reg_write, ex_wreg, mem_reg_write, mem_wreg,
        input  ex_branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_bubble, mem_wb_bubble,
        output stall_cnt, flush_cnt, busy
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for a 5-stage pipeline
// Define HAZARD_FWD_EN when the datapath has full EX/MEM forwarding (only load-use stalls).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    hz_state_t state;
    hz_state_t state_nxt;
    hz_ctrl_t  ctrl;
    logic      mem_wait;
    logic      hit_rs;
    logic      hit_rt;
    logic      data_hazard;

    assign mem_wait = bus.dmem_req && !bus.dmem_ready;

`ifdef HAZARD_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_reg_write, bus.mem_reg_write, bus.mem_wreg};
    assign hit_rs = bus.ex_mem_read && (bus.id_rs == bus.ex_wreg);
    assign hit_rt = bus.ex_mem_read && (bus.id_rt == bus.ex_wreg);
`else
    // Without forwarding any in-flight writer of a source register must drain first.
    assign hit_rs = ((bus.ex_mem_read || bus.ex_reg_write) && (bus.id_rs == bus.ex_wreg))
                 || (bus.mem_reg_write && (bus.id_rs == bus.mem_wreg));
    assign hit_rt = ((bus.ex_mem_read || bus.ex_reg_write) && (bus.id_rt == bus.ex_wreg))
                 || (bus.mem_reg_write && (bus.id_rt == bus.mem_wreg));
`endif

    assign data_hazard = (bus.id_rs_used && (bus.id_rs != '0) && hit_rs)
                      || (bus.id_rt_used && (bus.id_rt != '0) && hit_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nxt = ST_MEM_WAIT;
                end else if (bus.ex_branch_taken) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Gated by rst_n so the pipeline sees a clean idle bundle while reset is held.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    if (mem_wait) begin
                        ctrl = CTRL_MEM_WAIT;
                    end else if (bus.ex_branch_taken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (data_hazard) begin
                        ctrl = CTRL_STALL;
                    end else if (bus.id_jump) begin
                        ctrl = CTRL_FLUSH;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!bus.dmem_ready) begin
                        ctrl = CTRL_MEM_WAIT;
                    end
                end
                ST_FLUSH: ctrl = CTRL_FLUSH;
                default:  ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.if_id_write   = ctrl.if_id_write;
    assign bus.id_ex_write   = ctrl.id_ex_write;
    assign bus.ex_mem_write  = ctrl.ex_mem_write;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    assign bus.busy          = (state != ST_RUN);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctrl.pc_write),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.if_id_flush),
        .count (bus.flush_cnt)
    );

endmodule
